// File: rtl/uart_rx_sample_loader_if.sv
// Bus between the UART sample loader and its surroundings: serial line and restart in,
// complex-sample write port and status strobes out.
interface uart_rx_sample_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                     rx_i;
  logic                     clr_i;
  logic                     wr_en_o;
  logic [ADDR_W-1:0]        wr_addr_o;
  logic signed [DATA_W-1:0] wr_real_o;
  logic signed [DATA_W-1:0] wr_imag_o;
  logic                     frame_done_o;
  logic                     frame_err_o;
  logic                     busy_o;

  modport master (
    input  rx_i, clr_i,
    output wr_en_o, wr_addr_o, wr_real_o, wr_imag_o, frame_done_o, frame_err_o, busy_o
  );

  modport slave (
    output rx_i, clr_i,
    input  wr_en_o, wr_addr_o, wr_real_o, wr_imag_o, frame_done_o, frame_err_o, busy_o
  );
endinterface

// File: rtl/uart_rx_sample_loader.sv
// UART receiver that pairs signed bytes (real, then imaginary) into complex samples
// and writes them to sequential addresses of the FFT input buffer.
module uart_rx_sample_loader #(
  parameter int CLKS_PER_BIT = 10,
  parameter int N            = 256,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  uart_rx_sample_loader_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_sync_q, rx_sync_d;
  logic                     rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic                     phase_q, phase_d;
  logic [ADDR_W-1:0]        count_q, count_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic signed [DATA_W-1:0] wr_real_q, wr_real_d;
  logic signed [DATA_W-1:0] wr_imag_q, wr_imag_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_err_q, frame_err_d;
  logic                     stop_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      phase_q      <= 1'b0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_real_q    <= '0;
      wr_imag_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_real_q    <= wr_real_d;
      wr_imag_q    <= wr_imag_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Bit timing: every counter wrap lands mid-bit, so STOP exits half a bit before the line
  // could carry the next start edge.
  always_comb begin
    rx_meta_d = bus.rx_i;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_tick = 1'b0;
    if (bus.clr_i) begin
      state_d   = IDLE;
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          clk_cnt_d = '0;
          if (rx_prev_q && !rx_sync_q) begin
            state_d   = START;
            bit_idx_d = '0;
          end
        end
        START: begin
          if (clk_cnt_q == HALF_M1) begin
            clk_cnt_d = '0;
            state_d   = rx_sync_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (clk_cnt_q == BIT_M1) begin
            clk_cnt_d = '0;
            shift_d   = {rx_sync_q, shift_q[DATA_W-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_d = STOP;
          end
        end
        STOP: begin
          if (clk_cnt_q == BIT_M1) begin
            clk_cnt_d = '0;
            stop_tick = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte pairing and write-port outputs; data/address hold between strobes.
  always_comb begin
    bus.busy_o   = (state_q != IDLE);
    hold_d       = hold_q;
    phase_d      = phase_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_real_d    = wr_real_q;
    wr_imag_d    = wr_imag_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    if (bus.clr_i) begin
      phase_d = 1'b0;
      count_d = '0;
    end else if (stop_tick) begin
      if (!rx_sync_q) begin
        frame_err_d = 1'b1;
        phase_d     = 1'b0;
      end else if (!phase_q) begin
        hold_d  = $signed(shift_q);
        phase_d = 1'b1;
      end else begin
        wr_en_d      = 1'b1;
        wr_addr_d    = count_q;
        wr_real_d    = hold_q;
        wr_imag_d    = $signed(shift_q);
        frame_done_d = (count_q == LAST_ADDR);
        count_d      = count_q + 1'b1;
        phase_d      = 1'b0;
      end
    end
  end

  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_real_o    = wr_real_q;
  assign bus.wr_imag_o    = wr_imag_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.frame_err_o  = frame_err_q;

endmodule

// File: doc/uart_rx_sample_loader.md
Name: uart_rx_sample_loader

Overview:
- UART receiver that deframes a serial byte stream of interleaved signed 8-bit samples (real byte, then imaginary byte) into complex samples.
- Writes each sample into the FFT input buffer, one write per sample, with a sequential address.
- Sits between the board UART pin and the FFT sample RAM.
- Pulses a frame-done strobe after N complex samples so the FFT can start.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per UART bit (must be >= 4).
- N, 256, complex samples per frame (power of two).
- DATA_W, 8, sample width in bits (byte-wide UART payload).
- ADDR_W, 8, write-address width, equal to log2(N).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- rx_i  input  1  asynchronous UART line, idle high.
- clr_i  input  1  synchronous frame restart (clears address and pairing phase, aborts current byte).
- wr_en_o  output  1  one-cycle write strobe for a complete complex sample.
- wr_addr_o  output  ADDR_W  sample index 0..N-1.
- wr_real_o  output  DATA_W  signed real part.
- wr_imag_o  output  DATA_W  signed imaginary part.
- frame_done_o  output  1  one-cycle pulse coincident with the write of sample N-1.
- frame_err_o  output  1  one-cycle pulse when a stop bit samples low.
- busy_o  output  1  high while the state machine is not in IDLE.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0, every output is 0, the state is IDLE, the address counter and pairing phase are 0, and both synchronizer flops are set to 1.
- Input sync: two-flop synchronizer on rx_i, which adds 2 cycles of latency. All decisions use the synchronized value.
- IDLE: a synchronized 1->0 transition moves to START and loads the bit counter.
- START: wait CLKS_PER_BIT/2 cycles to reach mid-bit.
  - Line still 0: move to DATA.
  - Line 1: glitch; return to IDLE with no outputs.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 samples into a shift register, then move to STOP.
- STOP: sample after a further CLKS_PER_BIT cycles, then return to IDLE immediately. Returning at mid-stop-bit leaves half a bit to detect a back-to-back start bit with zero idle gap, which must be supported.
  - Line 1: byte valid.
  - Line 0: pulse frame_err_o, discard the byte, reset the pairing phase to "real", do not advance the address.
- Pairing:
  - Valid byte with phase=real: latch it into the real holding register and set phase=imag.
  - Valid byte with phase=imag, on the cycle after the stop sample:
    - wr_en_o=1 for exactly one cycle;
    - wr_real_o = holding register, wr_imag_o = the byte;
    - wr_addr_o = current count;
    - then the count increments and phase returns to real.
- Addressing: the count wraps from N-1 to 0. frame_done_o=1 in the same cycle as the wr_en_o whose address is N-1.
- Output hold: data and address outputs hold their values between strobes.
- clr_i=1:
  - next cycle the state is IDLE, count=0 and phase=real;
  - any partial byte is dropped;
  - no wr_en_o, frame_done_o or frame_err_o in that cycle.
- Priority: rst_n over clr_i over normal operation.
- Samples are two's complement: 0x80 is -128 and 0x7F is +127. No sign extension or scaling is applied.

Test Plan:
- Single sample: send bytes 0x7F then 0x00, 10 clks/bit, idle gaps -> one wr_en_o pulse, addr 0, real=127, imag=0, no other strobes.
- Back-to-back: with N=8, ADDR_W=3, send 16 bytes with zero idle gap, where each stop bit is immediately followed by a start bit -> 8 writes at addr 0..7, frame_done_o only with addr 7. A 17th/18th byte pair writes addr 0.
- Negative values: send bytes 0x80, 0xF6 -> real=-128, imag=-10.
- Framing error: send 0x11 with stop bit forced 0, then 0x22, 0x33 -> frame_err_o pulses once; a single write follows with real=0x22, imag=0x33 at the unchanged address.
- Glitch: drive rx_i low for 3 clks, then high -> no write, no error, busy_o returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Mid-byte abort: assert clr_i during data bit 4 of a real byte, then send 0x05, 0x06 -> write at addr 0 with real=5, imag=6. Repeat with rst_n low for 1 cycle -> all outputs 0 the next cycle, same recovery.
